// File: rtl/kyber_pkg.sv
// Shared Kyber NTT datapath constants and coefficient types.
package kyber_pkg;

  localparam int unsigned DATA_WIDTH = 12;
  localparam logic [DATA_WIDTH-1:0] Q = 12'd3329;

  typedef logic [DATA_WIDTH-1:0] coeff_t;
  typedef logic [DATA_WIDTH:0]   coeff_sum_t;

endpackage

// File: rtl/mod_reduce_once.sv
// Single conditional subtract of Q: maps [0, 2^(W+1)) down by at most one modulus.
module mod_reduce_once #(
  parameter int unsigned         W = kyber_pkg::DATA_WIDTH,
  parameter logic [W-1:0]        Q = kyber_pkg::Q
) (
  input  logic [W:0]   sum_i,
  output logic [W-1:0] z_o
);

  logic [W:0] q_ext;
  logic [W:0] diff;

  assign q_ext = {1'b0, Q};
  assign diff  = sum_i - q_ext;
  // Both legs are truncated to W bits, which also defines the out-of-range result.
  assign z_o   = (sum_i >= q_ext) ? diff[W-1:0] : sum_i[W-1:0];

endmodule

// File: rtl/modular_add_pipe.sv
// Elastic two-stage modular adder z = (x + y) mod Q with valid/ready on both sides.
module modular_add_pipe #(
  parameter int unsigned          DATA_WIDTH = kyber_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] Q         = kyber_pkg::Q
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] x_add,
  input  logic [DATA_WIDTH-1:0] y_add,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] z_add
);

  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH:0]   s1_sum_q,   s1_sum_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0] s2_z_q,     s2_z_d;
  logic [DATA_WIDTH-1:0] s1_reduced;
  logic                  adv1, adv2;

  mod_reduce_once #(
    .W (DATA_WIDTH),
    .Q (Q)
  ) u_reduce (
    .sum_i (s1_sum_q),
    .z_o   (s1_reduced)
  );

  // A stage may advance when it is empty or the stage after it is moving.
  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1 && !rst;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s2_valid_d = s2_valid_q;
    s2_z_d     = s2_z_q;
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_z_d = s1_reduced;
      end
    end
    if (adv1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sum_d = {1'b0, x_add} + {1'b0, y_add};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_z_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sum_q   <= s1_sum_d;
      s2_valid_q <= s2_valid_d;
      s2_z_q     <= s2_z_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign z_add     = s2_z_q;

endmodule

// File: tb/tb_modular_add_pipe.sv
// Self-checking bench for modular_add_pipe: queue-based reference model plus directed literal checks.
module tb_modular_add_pipe;

  localparam int unsigned DW = 12;
  localparam int          QM = 3329;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] x_add;
  logic [DW-1:0] y_add;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] z_add;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_q[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_z     = '0;
  int            out_count  = 0;

  modular_add_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_add     (x_add),
    .y_add     (y_add),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z_add     (z_add)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer sum, one subtract when >= Q, then wrap to DW bits.
  function automatic logic [DW-1:0] model(input int x, input int y);
    int s;
    s = x + y;
    if (s >= QM) s = s - QM;
    return DW'(s % (1 << DW));
  endfunction

  // Scoreboard and stall-hold monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_z", 32'(z_add), 32'(prev_z));
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("stale_out_valid", 32'(out_valid), 32'd0);
        end else if (out_ready) begin
          check("sb_z", 32'(z_add), 32'(exp_q.pop_front()));
          out_count++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(int'(x_add), int'(y_add)));
      prev_stall = out_valid && !out_ready;
      prev_z     = z_add;
    end
  end

  // Present one pair and hold it until accepted.
  task automatic send(input int x, input int y);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    x_add    = DW'(x);
    y_add    = DW'(y);
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
  endtask

  // One isolated transfer with latency and value checked against a literal.
  task automatic single(input int x, input int y, input int exp, input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    x_add    = DW'(x);
    y_add    = DW'(y);
    @(negedge clk);
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({name, "_early_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_z"}, 32'(z_add), 32'(exp));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start_cnt;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_add     = '0;
    y_add     = '0;

    // Reset and idle
    idle(3);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_z", 32'(z_add), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    idle(2);
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_z", 32'(z_add), 32'd0);

    // Directed singles, boundaries and an out-of-range pair
    single(1000, 2000, 3000, "s_1000_2000");
    single(2000, 1500, 171, "s_2000_1500");
    single(3328, 1, 0, "s_3328_1");
    single(3328, 3328, 3327, "s_max");
    single(0, 0, 0, "s_zero");
    single(1664, 1664, 3328, "s_qm1");
    single(1700, 1629, 0, "s_q");
    single(2, 3328, 1, "s_qp1");
    single(4095, 4095, 765, "s_oor");
    idle(3);

    // Streaming 64 random pairs back-to-back
    out_ready = 1'b1;
    start_cnt = out_count;
    for (int i = 0; i < 64; i++) send(int'($urandom_range(0, QM - 1)), int'($urandom_range(0, QM - 1)));
    idle(4);
    check("stream_count", 32'(out_count - start_cnt), 32'd64);

    // Backpressure with three queued pairs
    out_ready = 1'b0;
    send(5, 6);
    send(7, 8);
    in_valid = 1'b1;
    x_add    = DW'(3000);
    y_add    = DW'(400);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_z", 32'(z_add), 32'd11);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    start_cnt = out_count;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    idle(5);
    check("bp_count", 32'(out_count - start_cnt), 32'd3);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Random valid/ready traffic
    for (int i = 0; i < 2000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      x_add     = DW'($urandom_range(0, QM - 1));
      y_add     = DW'($urandom_range(0, QM - 1));
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(5);
    check("rand_drained", 32'(exp_q.size()), 32'd0);

    // Sweep x = Q-1 across every y
    for (int y = 0; y < QM; y++) send(QM - 1, y);
    idle(5);
    check("sweep_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-stream discards in-flight results
    out_ready = 1'b0;
    send(100, 200);
    send(300, 400);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_z", 32'(z_add), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    idle(2);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    idle(5);
    @(negedge clk);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    single(1234, 2345, 250, "s_after_rst");
    idle(3);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
